vga_fb_write_arbiter: RTL and testbench
=======================================

Name: vga_fb_write_arbiter

Overview:
- Shares the single write port of the VGA framebuffer between two requesters:
  - CPU pixel stores, arriving on the same signals as ctrl_MEM_VGAE / debug_vga_address / debug_vga_in.
  - A built-in hardware screen-fill engine.
- Buffers CPU stores in a small FIFO and stalls the pipeline when that FIFO is full.
- Guarantees program-order semantics: stores issued before a fill land before it; stores issued after a fill land after it.
- Sits between the processor MEM stage and the framebuffer RAM.

Parameters:
- FB_PIXELS, 307200, number of pixels written by a fill (640x480); addresses 0..FB_PIXELS-1.
- ADDR_W, 19, framebuffer address width.
- DATA_W, 8, pixel colour width.
- FIFO_DEPTH, 4, CPU store buffer entries (power of two, >=2).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cpu_we  in  1  CPU store request (ctrl_MEM_VGAE).
- cpu_addr  in  ADDR_W  CPU store address.
- cpu_data  in  DATA_W  CPU store colour.
- cpu_stall  out  1  FIFO full; CPU must hold its request.
- fill_start  in  1  single-cycle request to fill the screen.
- fill_color  in  DATA_W  fill colour, sampled with fill_start.
- fill_busy  out  1  a fill is accepted and not yet complete.
- fill_done  out  1  one-cycle pulse after the last fill pixel is written.
- fb_we  out  1  registered framebuffer write enable.
- fb_addr  out  ADDR_W  registered write address.
- fb_data  out  DATA_W  registered write data.

Behaviour:
- Reset values:
  - fb_we=0, fb_addr=0, fb_data=0.
  - fill_busy=0, fill_done=0.
  - FIFO empty, so cpu_stall=0.
  - State IDLE; any in-progress fill is aborted with no fill_done.
- cpu_stall = (count==FIFO_DEPTH), combinational from the registered count.
- Enqueue: cpu_we && !cpu_stall pushes {addr,data}. cpu_we while stalled is ignored.
- Simultaneous push and pop is legal in the same cycle, including when full: the pop frees a slot, but stall is still judged on the pre-edge count.
- States:
  - IDLE: pop one entry per cycle while the FIFO is non-empty. fb_* is loaded from the popped entry at that edge, so fb_we is high for the following cycle.
  - On fill_start in IDLE: latch fill_color; pre_cnt <= count (entries ahead of the fill); fill_busy <= 1. Go to PRE_DRAIN if pre_cnt != 0, else go to FILL with ptr=0.
  - PRE_DRAIN: pop one entry per cycle, decrementing pre_cnt. New pushes are allowed and are counted as post-fill entries. When pre_cnt reaches 0, go to FILL, ptr=0.
  - FILL: each cycle, fb_we=1, fb_addr=ptr, fb_data=colour, ptr++. No FIFO pops; pushes continue until the FIFO is full.
    - After issuing address FB_PIXELS-1: fill_busy <= 0, fill_done pulses for 1 cycle, go to IDLE.
    - The pop of post-fill entries may start on the cycle after the last fill write.
- fill_start outside IDLE is ignored; there is no queueing of a second fill.
- The ptr counter is ADDR_W bits wide and never wraps, since FB_PIXELS <= 2^ADDR_W.
- Latency:
  - CPU store with an empty FIFO in IDLE: pushed at edge k, popped at edge k+1, fb_we high during cycle k+1..k+2.
  - Fill of N pixels from an empty FIFO: first write one cycle after the fill_start edge; fill_done N cycles after that first write.
- fb_we is 0 in any cycle with no pop and no fill write.
- Reset asserted mid-fill or mid-drain: all outputs go to reset values immediately (asynchronous), and FIFO contents are discarded.

Decomposition:
- Shared package (vga_pkg):
  - FB_PIXELS, ADDR_W, DATA_W.
  - State encoding: IDLE=2'd0, PRE_DRAIN=2'd1, FILL=2'd2.
- One natural sub-module: fb_store_fifo (synchronous FIFO, FIFO_DEPTH x (ADDR_W+DATA_W)) with push, pop, count, full, empty.
- Arbitration FSM and fill counter stay in the top level.

Test Plan (bench overrides FB_PIXELS=16):
- Reset then single store addr=0x00100, data=0x1F → one cycle later fb_we=1, fb_addr=0x00100, fb_data=0x1F for exactly 1 cycle. cpu_stall never asserts.
- fill_start with colour=0xE0 and FIFO empty → fb_we high for 16 consecutive cycles, fb_addr 0..15 in order, all data 0xE0. fill_busy high throughout. fill_done pulses once on the cycle after address 15.
- Push 3 stores A,B,C, then fill_start the next cycle, then push D,E,F,G,H during the fill → output order is A,B,C, then addresses 0..15, then D,E,F,G. cpu_stall rises when the FIFO holds 4 post-fill entries, so H is held. H appears after G once stall drops.
- Continuous cpu_we with FIFO_DEPTH stores during FILL → cpu_stall=1 after the 4th push. The held store is accepted on the first cycle after the fill ends. No store is lost or duplicated.
- fill_start pulsed again mid-fill → ignored: exactly 16 fill writes and one fill_done.
- Reset asserted asynchronously at fill pixel 7 with 2 entries queued → fb_we=0 and fill_busy=0 immediately. No fill_done. After reset release, fb_we stays 0 (FIFO empty).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared framebuffer geometry and arbiter state encoding.
// Constants only; no logic, no latency, no flow control.
package vga_pkg;

   localparam int FB_PIXELS = 307200;
   localparam int ADDR_W    = 19;
   localparam int DATA_W    = 8;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] PRE_DRAIN = 2'd1;
   localparam logic [1:0] FILL      = 2'd2;

endpackage

// File: rtl/fb_store_fifo.sv
// Synchronous FIFO buffering CPU pixel stores; data visible at the head with zero latency.
// Push is dropped when full, pop is dropped when empty; push and pop may share a cycle.
module fb_store_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 27,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [W-1:0]     push_dat,
   input  logic             pop,
   output logic [W-1:0]     pop_dat,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/vga_fb_write_arbiter.sv
// Arbitrates the framebuffer write port between buffered CPU stores and a screen-fill engine.
// Store: 1 cycle push->pop, fb_* registered; fill: 1 write/cycle; cpu_stall holds the CPU when the FIFO is full.
module vga_fb_write_arbiter #(
   parameter int FB_PIXELS  = vga_pkg::FB_PIXELS,
   parameter int ADDR_W     = vga_pkg::ADDR_W,
   parameter int DATA_W     = vga_pkg::DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_stall,
   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_color,
   output logic              fill_busy,
   output logic              fill_done,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_data
);

   import vga_pkg::*;

   localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int                ENT_W     = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_PIXELS - 1);

   logic [1:0]        state;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  pre_cnt;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] color;
   logic              last_wr;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              fill_accept;
   logic [ENT_W-1:0]  pop_dat;
   logic [ADDR_W-1:0] pop_addr;
   logic [DATA_W-1:0] pop_data;

   assign cpu_stall   = full;
   assign push        = cpu_we && !cpu_stall;
   // A fill is not re-armed until the previous fill_done has been issued.
   assign fill_accept = (state == IDLE) && fill_start && !fill_busy;
   // No pop on the accepting cycle, so count is exactly the set of stores ahead of the fill.
   assign pop         = !empty && (((state == IDLE) && !fill_accept) || (state == PRE_DRAIN));
   assign {pop_addr, pop_data} = pop_dat;

   fb_store_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENT_W)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push),
      .push_dat ({cpu_addr, cpu_data}),
      .pop      (pop),
      .pop_dat  (pop_dat),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pre_cnt   <= '0;
         ptr       <= '0;
         color     <= '0;
         last_wr   <= 1'b0;
         fill_busy <= 1'b0;
         fill_done <= 1'b0;
         fb_we     <= 1'b0;
         fb_addr   <= '0;
         fb_data   <= '0;
      end else begin
         fb_we     <= 1'b0;
         last_wr   <= 1'b0;
         fill_done <= last_wr;
         if (last_wr) fill_busy <= 1'b0;

         if (pop) begin
            fb_we   <= 1'b1;
            fb_addr <= pop_addr;
            fb_data <= pop_data;
         end

         case (state)
            IDLE: begin
               if (fill_accept) begin
                  color     <= fill_color;
                  pre_cnt   <= count;
                  ptr       <= '0;
                  fill_busy <= 1'b1;
                  state     <= (count != '0) ? PRE_DRAIN : FILL;
               end
            end
            PRE_DRAIN: begin
               pre_cnt <= pre_cnt - 1'b1;
               if (pre_cnt == CNT_W'(1)) state <= FILL;
            end
            FILL: begin
               fb_we   <= 1'b1;
               fb_addr <= ptr;
               fb_data <= color;
               if (ptr == LAST_ADDR) begin
                  last_wr <= 1'b1;
                  state   <= IDLE;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Scoreboard bench: stimulus queues expected framebuffer writes in program order, a monitor pops on fb_we.
module tb_vga_fb_write_arbiter;

   localparam int AW    = 19;
   localparam int DW    = 8;
   localparam int PIX   = 16;
   localparam int DEPTH = 4;

   logic          clock;
   logic          reset;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_data;
   logic          cpu_stall;
   logic          fill_start;
   logic [DW-1:0] fill_color;
   logic          fill_busy;
   logic          fill_done;
   logic          fb_we;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_data;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int wr_cnt = 0;
   logic [AW+DW-1:0] exp_q[$];

   vga_fb_write_arbiter #(
      .FB_PIXELS  (PIX),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data),
      .cpu_stall  (cpu_stall),
      .fill_start (fill_start),
      .fill_color (fill_color),
      .fill_busy  (fill_busy),
      .fill_done  (fill_done),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: every framebuffer write must match the head of the expected queue.
   always @(negedge clock) begin
      if (!reset && fill_done) done_cnt++;
      if (!reset && fb_we) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", fb_addr, fb_data);
         end else begin
            check("fb_write", 32'({fb_addr, fb_data}), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Present a store and hold it until accepted; reports how many cycles stall held it.
   task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
      cpu_we   = 1'b1;
      cpu_addr = a;
      cpu_data = d;
      waited   = 0;
      @(negedge clock);
      while (cpu_stall && waited < 100) begin
         waited++;
         @(negedge clock);
      end
      if (cpu_stall) begin
         checks++;
         errors++;
         $display("FAIL store_timeout: got stall=1, expected acceptance");
      end
      @(posedge clock);
      exp_q.push_back({a, d});
      #1 cpu_we = 1'b0;
   endtask

   task automatic fill(input logic [DW-1:0] c);
      fill_color = c;
      fill_start = 1'b1;
      @(posedge clock);
      for (int i = 0; i < PIX; i++) exp_q.push_back({AW'(i), c});
      #1 fill_start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!fill_done && n < 60) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(fill_done), 32'd1);
      step(1);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      step(2);
   endtask

   initial begin
      int w;
      int cyc;
      int d0;
      int w0;
      cpu_we = 0; cpu_addr = '0; cpu_data = '0;
      fill_start = 0; fill_color = '0;
      reset = 1'b1;
      #2;
      check("rst_fb_we", 32'(fb_we), 0);
      check("rst_fb_addr", 32'(fb_addr), 0);
      check("rst_fb_data", 32'(fb_data), 0);
      check("rst_busy", 32'(fill_busy), 0);
      check("rst_done", 32'(fill_done), 0);
      check("rst_stall", 32'(cpu_stall), 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      step(1);

      // Single store: written one cycle after acceptance, for exactly one cycle.
      store(19'h00100, 8'h1F, w);
      check("store_no_stall", 32'(w), 0);
      @(negedge clock);
      check("store_lat_cycle0", 32'(fb_we), 0);
      @(negedge clock);
      check("store_we", 32'(fb_we), 1);
      check("store_addr", 32'(fb_addr), 32'h100);
      check("store_data", 32'(fb_data), 32'h1F);
      @(negedge clock);
      check("store_one_cycle", 32'(fb_we), 0);
      step(1);

      // Fill from empty FIFO: done visible 18 negedges after the accepting edge.
      d0 = done_cnt;
      fill(8'hE0);
      @(negedge clock);
      check("fill_busy", 32'(fill_busy), 1);
      cyc = 1;
      while (!fill_done && cyc < 60) begin
         @(negedge clock);
         cyc++;
      end
      check("fill_done_latency", 32'(cyc), 32'd18);
      check("fill_busy_cleared", 32'(fill_busy), 0);
      step(3);
      check("fill_done_once", 32'(done_cnt - d0), 1);
      check("fill_all_written", 32'(exp_q.size()), 0);

      // Stores ahead of a fill drain first; H stalls behind four post-fill stores.
      store(19'h0000A, 8'hA1, w);
      store(19'h0000B, 8'hB2, w);
      store(19'h0000C, 8'hC3, w);
      fill(8'h1C);
      store(19'h000D0, 8'hD4, w);
      check("post_d_wait", 32'(w), 0);
      store(19'h000E0, 8'hE5, w);
      store(19'h000F0, 8'hF6, w);
      store(19'h00010, 8'h07, w);
      check("post_g_wait", 32'(w), 0);
      store(19'h00011, 8'h18, w);
      check("post_h_stall_cycles", 32'(w), 32'd14);
      wait_drain("order_drain");

      // Continuous stores during a fill from empty; the 5th is held until the fill ends.
      fill(8'h3C);
      store(19'h00020, 8'h21, w);
      store(19'h00021, 8'h22, w);
      store(19'h00022, 8'h23, w);
      store(19'h00023, 8'h24, w);
      @(negedge clock);
      check("stall_after_4", 32'(cpu_stall), 1);
      step(0);
      store(19'h00024, 8'h25, w);
      check("held_store_wait", 32'(w), 32'd12);
      wait_drain("stall_drain");

      // Second fill_start mid-fill is ignored.
      d0 = done_cnt;
      w0 = wr_cnt;
      fill(8'h55);
      step(5);
      fill_color = 8'hAA;
      fill_start = 1'b1;
      step(1);
      fill_start = 1'b0;
      wait_done("mid_fill_done");
      step(10);
      check("mid_fill_one_done", 32'(done_cnt - d0), 1);
      check("mid_fill_16_writes", 32'(wr_cnt - w0), 32'd16);

      // Asynchronous reset at fill pixel 7 with two stores queued.
      fill(8'h33);
      store(19'h00030, 8'h31, w);
      store(19'h00031, 8'h32, w);
      cyc = 0;
      @(negedge clock);
      while (!(fb_we && fb_addr == 19'd7) && cyc < 40) begin
         @(negedge clock);
         cyc++;
      end
      check("reached_pixel7", 32'(fb_addr), 32'd7);
      #2 reset = 1'b1;
      #1;
      check("arst_fb_we", 32'(fb_we), 0);
      check("arst_busy", 32'(fill_busy), 0);
      check("arst_stall", 32'(cpu_stall), 0);
      exp_q.delete();
      d0 = done_cnt;
      w0 = wr_cnt;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      step(20);
      check("arst_no_done", 32'(done_cnt - d0), 0);
      check("arst_no_writes", 32'(wr_cnt - w0), 0);
      check("arst_fb_we_idle", 32'(fb_we), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

endmodule
